// File: rtl/led_pattern_engine_if.sv
// Game-side connection to the LED pattern engine: state, tick, table writes and LED drive.
// Latency: wires only, no storage.
// Backpressure: none; every strobe is taken on the clock edge where it is high.
interface led_pattern_engine_if #(
  parameter int NUM_LEDS = 8,
  parameter int GROUP_W  = 3
);

  logic                led_tick;
  logic [2:0]          state;
  logic [GROUP_W-1:0]  selected_group;
  logic                tbl_wr_en;
  logic [GROUP_W-1:0]  tbl_wr_addr;
  logic [NUM_LEDS-1:0] tbl_wr_data;
  logic [NUM_LEDS-1:0] LED;
  logic                sweep_end;

  // Game FSM / tick divider side.
  modport master (
    output led_tick, state, selected_group, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    input  LED, sweep_end
  );

  // Engine side.
  modport slave (
    input  led_tick, state, selected_group, tbl_wr_en, tbl_wr_addr, tbl_wr_data,
    output LED, sweep_end
  );

endinterface

// File: rtl/led_pattern_engine.sv
// LED bar driver: bouncing scanner, all-on, table patterns, blink-on-hold, off.
// Latency: LED and sweep_end are registered, one cycle behind the inputs.
// Backpressure: none; ticks and table writes are always accepted.
module led_pattern_engine #(
  parameter int NUM_LEDS  = 8,
  parameter int POS_W     = 3,
  parameter int GROUP_W   = 3,
  parameter int BLINK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  led_pattern_engine_if.slave   bus
);

  localparam int                  NUM_GROUPS = 2 ** GROUP_W;
  localparam int                  CNT_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [POS_W-1:0]    POS_LAST   = POS_W'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(BLINK_DIV - 1);
  localparam logic [NUM_LEDS-1:0] MSB_ONLY   = {1'b1, {(NUM_LEDS-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_GET   = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Registered state.
  logic [POS_W-1:0]    pos_q,       pos_d;
  dir_e                dir_q,       dir_d;
  logic [CNT_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                blink_on_q,  blink_on_d;
  logic [NUM_LEDS-1:0] hold_q,      hold_d;
  logic [NUM_LEDS-1:0] led_q,       led_d;
  logic                sweep_end_q, sweep_end_d;
  game_state_e         prev_state_q;
  logic [NUM_LEDS-1:0] tbl_q [NUM_GROUPS];

  // Decoded current-cycle conditions.
  game_state_e         game_st;
  logic                enter_reset;
  logic                enter_get;
  logic                scan_step;
  logic [POS_W-1:0]    pos_cur;
  logic [NUM_LEDS-1:0] hold_cur;
  logic                blink_on_cur;

  assign game_st     = game_state_e'(bus.state);
  assign enter_reset = (game_st == ST_RESET) && (prev_state_q != ST_RESET);
  assign enter_get   = (game_st == ST_GET)   && (prev_state_q != ST_GET);
  // The entry load wins over a coincident tick, so a tick only steps
  // the scanner once RESET has been held for at least one cycle.
  assign scan_step   = (game_st == ST_RESET) && bus.led_tick && !enter_reset;

  // Values seen by the LED selector this cycle: an entry load takes effect
  // immediately, so the first output after entry already shows it.
  assign pos_cur      = enter_reset ? '0    : pos_q;
  assign hold_cur     = enter_get   ? led_q : hold_q;
  assign blink_on_cur = enter_get   ? 1'b1  : blink_on_q;

  // Scanner next position/direction and end-of-sweep pulse.
  always_comb begin
    pos_d       = pos_q;
    dir_d       = dir_q;
    sweep_end_d = 1'b0;
    if (enter_reset) begin
      pos_d = '0;
      dir_d = DIR_UP;
    end else if (scan_step) begin
      // Direction flips on arrival at an end so the end is shown once.
      if (dir_q == DIR_UP) begin
        pos_d = pos_q + POS_W'(1);
        if (pos_d == POS_LAST) dir_d = DIR_DOWN;
      end else begin
        pos_d = pos_q - POS_W'(1);
        if (pos_d == '0) dir_d = DIR_UP;
      end
      sweep_end_d = (pos_d == '0) || (pos_d == POS_LAST);
    end
  end

  // Blink divider and hold capture for the GET state.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    hold_d      = hold_q;
    if (enter_get) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
      hold_d      = led_q;
    end else if ((game_st == ST_GET) && bus.led_tick) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  // Next LED pattern chosen by game state.
  always_comb begin
    led_d = '0;
    case (game_st)
      ST_RESET: led_d = MSB_ONLY >> pos_cur;
      ST_WAIT:  led_d = '1;
      ST_START: led_d = tbl_q[bus.selected_group];
      ST_GET:   led_d = blink_on_cur ? hold_cur : '0;
      default:  led_d = '0;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q        <= '0;
      dir_q        <= DIR_UP;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      hold_q       <= '0;
      led_q        <= '0;
      sweep_end_q  <= 1'b0;
      prev_state_q <= ST_RESET;
    end else begin
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      hold_q       <= hold_d;
      led_q        <= led_d;
      sweep_end_q  <= sweep_end_d;
      prev_state_q <= game_st;
    end
  end

  // Pattern table: written at the edge, so a same-cycle read sees old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        tbl_q[g] <= '1;
      end
    end else if (bus.tbl_wr_en) begin
      tbl_q[bus.tbl_wr_addr] <= bus.tbl_wr_data;
    end
  end

  assign bus.LED       = led_q;
  assign bus.sweep_end = sweep_end_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: 8-LED and 12-LED instances driven in lockstep.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_led_pattern_engine;

  localparam int BD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        tick;
  logic [2:0]  st;
  logic [2:0]  sel;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;

  led_pattern_engine_if #(.NUM_LEDS(8),  .GROUP_W(3)) bus8 ();
  led_pattern_engine_if #(.NUM_LEDS(12), .GROUP_W(3)) bus12 ();

  assign bus8.led_tick        = tick;
  assign bus8.state           = st;
  assign bus8.selected_group  = sel;
  assign bus8.tbl_wr_en       = we;
  assign bus8.tbl_wr_addr     = waddr;
  assign bus8.tbl_wr_data     = wdata[7:0];
  assign bus12.led_tick       = tick;
  assign bus12.state          = st;
  assign bus12.selected_group = sel;
  assign bus12.tbl_wr_en      = we;
  assign bus12.tbl_wr_addr    = waddr;
  assign bus12.tbl_wr_data    = wdata[11:0];

  led_pattern_engine #(.NUM_LEDS(8), .POS_W(3), .GROUP_W(3), .BLINK_DIV(BD)) dut8 (
    .clk(clk), .reset(rst), .bus(bus8));
  led_pattern_engine #(.NUM_LEDS(12), .POS_W(4), .GROUP_W(3), .BLINK_DIV(BD)) dut12 (
    .clk(clk), .reset(rst), .bus(bus12));

  int errors = 0;
  int checks = 0;

  // Behavioural reference, index 0 = 8 LEDs, index 1 = 12 LEDs.
  int          mk    [2];   // scanner ticks since last restart
  int          mg    [2];   // GET ticks since GET entry
  logic [15:0] mled  [2];
  logic [15:0] mhold [2];
  logic        msweep[2];
  logic [2:0]  mprev [2];
  logic [15:0] mtbl  [2][8];

  function automatic int nleds(input int i);
    return (i == 0) ? 8 : 12;
  endfunction

  // Position after k steps of a bounce over 0..n-1 starting at 0 going up.
  function automatic int bounce(input int k, input int n);
    int period;
    int p;
    period = 2 * (n - 1);
    p = k % period;
    return (p < n) ? p : period - p;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int          n;
      logic [15:0] mask;
      logic [15:0] nxt;
      bit          ent_r;
      bit          ent_g;
      n    = nleds(i);
      mask = 16'((32'h1 << n) - 1);
      if (rst) begin
        mled[i] = '0; msweep[i] = 1'b0; mk[i] = 0; mg[i] = 0;
        mhold[i] = '0; mprev[i] = 3'd0;
        for (int j = 0; j < 8; j++) mtbl[i][j] = mask;
      end else begin
        ent_r = (st == 3'd0) && (mprev[i] != 3'd0);
        ent_g = (st == 3'd3) && (mprev[i] != 3'd3);
        case (st)
          3'd0:    nxt = 16'h1 << (n - 1 - bounce(ent_r ? 0 : mk[i], n));
          3'd1:    nxt = mask;
          3'd2:    nxt = mtbl[i][sel];
          3'd3:    nxt = ent_g ? mled[i] : ((((mg[i] / BD) % 2) == 0) ? mhold[i] : 16'h0);
          default: nxt = 16'h0;
        endcase
        msweep[i] = (st == 3'd0) && !ent_r && tick &&
                    ((bounce(mk[i] + 1, n) == 0) || (bounce(mk[i] + 1, n) == n - 1));
        if (ent_r) mk[i] = 0;
        else if ((st == 3'd0) && tick) mk[i] = mk[i] + 1;
        if (ent_g) begin
          mg[i]    = 0;
          mhold[i] = mled[i];
        end else if ((st == 3'd3) && tick) begin
          mg[i] = mg[i] + 1;
        end
        if (we) mtbl[i][waddr] = wdata & mask;
        mled[i]  = nxt;
        mprev[i] = st;
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock with the current inputs; DUTs compared against the model after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("model_led8",    16'(bus8.LED),        mled[0]);
    chk("model_sweep8",  16'(bus8.sweep_end),  16'(msweep[0]));
    chk("model_led12",   16'(bus12.LED),       mled[1]);
    chk("model_sweep12", 16'(bus12.sweep_end), 16'(msweep[1]));
    @(negedge clk);
  endtask

  typedef struct {
    logic        tick;
    logic [2:0]  state;
    logic [7:0]  led8;
    logic        sw8;
    logic [11:0] led12;
    logic        sw12;
  } vec_t;

  vec_t vt [17];

  initial begin
    // Sweep from reset: each row is one cycle, outputs show the pre-edge position.
    vt[0]  = '{1'b1, 3'd0, 8'h80, 1'b0, 12'h800, 1'b0};
    vt[1]  = '{1'b1, 3'd0, 8'h40, 1'b0, 12'h400, 1'b0};
    vt[2]  = '{1'b1, 3'd0, 8'h20, 1'b0, 12'h200, 1'b0};
    vt[3]  = '{1'b1, 3'd0, 8'h10, 1'b0, 12'h100, 1'b0};
    vt[4]  = '{1'b1, 3'd0, 8'h08, 1'b0, 12'h080, 1'b0};
    vt[5]  = '{1'b1, 3'd0, 8'h04, 1'b0, 12'h040, 1'b0};
    vt[6]  = '{1'b1, 3'd0, 8'h02, 1'b1, 12'h020, 1'b0};
    vt[7]  = '{1'b1, 3'd0, 8'h01, 1'b0, 12'h010, 1'b0};
    vt[8]  = '{1'b1, 3'd0, 8'h02, 1'b0, 12'h008, 1'b0};
    vt[9]  = '{1'b1, 3'd0, 8'h04, 1'b0, 12'h004, 1'b0};
    vt[10] = '{1'b1, 3'd0, 8'h08, 1'b0, 12'h002, 1'b1};
    vt[11] = '{1'b1, 3'd0, 8'h10, 1'b0, 12'h001, 1'b0};
    vt[12] = '{1'b1, 3'd0, 8'h20, 1'b0, 12'h002, 1'b0};
    vt[13] = '{1'b1, 3'd0, 8'h40, 1'b1, 12'h004, 1'b0};
    vt[14] = '{1'b1, 3'd0, 8'h80, 1'b0, 12'h008, 1'b0};
    vt[15] = '{1'b1, 3'd0, 8'h40, 1'b0, 12'h010, 1'b0};
    vt[16] = '{1'b0, 3'd0, 8'h20, 1'b0, 12'h020, 1'b0};

    rst = 1'b1; tick = 1'b0; st = 3'd0; sel = 3'd0;
    we = 1'b0; waddr = 3'd0; wdata = 16'h0;
    @(negedge clk);
    cycle();
    cycle();
    chk("reset_led8",   16'(bus8.LED),       16'h0);
    chk("reset_sweep8", 16'(bus8.sweep_end), 16'h0);
    chk("reset_led12",  16'(bus12.LED),      16'h0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      tick = vt[i].tick;
      st   = vt[i].state;
      cycle();
      chk($sformatf("sweep_led8[%0d]", i),    16'(bus8.LED),        16'(vt[i].led8));
      chk($sformatf("sweep_end8[%0d]", i),    16'(bus8.sweep_end),  16'(vt[i].sw8));
      chk($sformatf("sweep_led12[%0d]", i),   16'(bus12.LED),       16'(vt[i].led12));
      chk($sformatf("sweep_end12[%0d]", i),   16'(bus12.sweep_end), 16'(vt[i].sw12));
    end

    // Advance the 8-LED scanner to position 5, park in WAIT, re-enter RESET with a tick.
    tick = 1'b1;
    repeat (3) cycle();
    tick = 1'b0; st = 3'd1;
    cycle();
    chk("wait_all_on", 16'(bus8.LED), 16'hFF);
    cycle();
    cycle();
    st = 3'd0; tick = 1'b1;
    cycle();
    chk("reentry_led8",   16'(bus8.LED),       16'h80);
    chk("reentry_sweep8", 16'(bus8.sweep_end), 16'h0);
    chk("reentry_led12",  16'(bus12.LED),      16'h800);
    tick = 1'b0;
    cycle();
    chk("reentry_hold", 16'(bus8.LED), 16'h80);
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
    chk("reentry_step", 16'(bus8.LED), 16'h40);

    // Pattern table writes and group selection.
    we = 1'b1; waddr = 3'd2; wdata = 16'h0012;
    cycle();
    waddr = 3'd5; wdata = 16'h0092;
    cycle();
    we = 1'b0; st = 3'd2;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cycle();
      chk($sformatf("table_grp8[%0d]", s), 16'(bus8.LED),
          (s == 5) ? 16'h92 : (s == 2) ? 16'h12 : 16'hFF);
      chk($sformatf("table_grp12[%0d]", s), 16'(bus12.LED),
          (s == 5) ? 16'h092 : (s == 2) ? 16'h012 : 16'hFFF);
    end
    sel = 3'd2;
    cycle();
    we = 1'b1; waddr = 3'd2; wdata = 16'h0055;
    cycle();
    chk("rewrite_same_cycle", 16'(bus8.LED), 16'h12);
    we = 1'b0;
    cycle();
    chk("rewrite_visible", 16'(bus8.LED), 16'h55);
    we = 1'b1; wdata = 16'h0012;
    cycle();
    we = 1'b0;
    cycle();
    cycle();
    chk("restore_grp2", 16'(bus8.LED), 16'h12);

    // GET: hold the shown pattern and blink every BD ticks; group changes ignored.
    st = 3'd3; tick = 1'b0;
    cycle();
    chk("get_entry_hold", 16'(bus8.LED), 16'h12);
    for (int i = 0; i < 12; i++) begin
      tick = 1'b1;
      sel  = 3'(i);
      cycle();
      chk($sformatf("blink[%0d]", i), 16'(bus8.LED),
          (((i / BD) % 2) == 0) ? 16'h12 : 16'h00);
    end
    tick = 1'b0;
    cycle();
    chk("blink_off", 16'(bus8.LED), 16'h00);

    // Reset during blink-off clears outputs and table; scanner restarts.
    rst = 1'b1;
    cycle();
    chk("midreset_led8",   16'(bus8.LED),       16'h00);
    chk("midreset_sweep8", 16'(bus8.sweep_end), 16'h00);
    rst = 1'b0; st = 3'd2;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cycle();
      chk($sformatf("table_cleared[%0d]", s), 16'(bus8.LED), 16'hFF);
    end
    st = 3'd0;
    cycle();
    chk("restart_msb", 16'(bus8.LED), 16'h80);
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
    chk("restart_step", 16'(bus8.LED), 16'h40);

    // OVER and unused codes blank the bar.
    st = 3'd1; cycle();
    st = 3'd4; cycle();
    chk("over_off", 16'(bus8.LED), 16'h00);
    st = 3'd1; cycle();
    st = 3'd6; cycle();
    chk("code6_off", 16'(bus8.LED), 16'h00);
    st = 3'd7; cycle();
    chk("code7_off_12", 16'(bus12.LED), 16'h000);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      rst  = ($urandom_range(0, 249) == 0);
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) begin
        r = int'($urandom_range(0, 9));
        if (r < 3)      st = 3'd0;
        else if (r < 4) st = 3'd1;
        else if (r < 6) st = 3'd2;
        else if (r < 9) st = 3'd3;
        else            st = 3'($urandom_range(4, 7));
      end
      sel   = 3'($urandom_range(0, 7));
      we    = ($urandom_range(0, 5) == 0);
      waddr = 3'($urandom_range(0, 7));
      wdata = 16'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
